spi_txn_arbiter: RTL

SPI_TXN_ARBITER -- requirements
Module: spi_txn_arbiter

---
 rtl/spi_txn_arbiter_pkg.sv | 27 ++
 rtl/spi_txn_arbiter_if.sv | 30 +++
 rtl/spi_txn_arbiter_rr_pick.sv | 29 ++
 rtl/spi_txn_arbiter.sv | 106 ++++++++++
 4 files changed

// File: rtl/spi_txn_arbiter_pkg.sv
// Shared constants for the SPI transaction arbiter: FSM encoding, frame widths, R/W mode bits.
package spi_arb_pkg;

    localparam int unsigned CMD_W  = 16;
    localparam int unsigned DATA_W = 8;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_XFER    = 2'd1;
    localparam logic [1:0] ST_RELEASE = 2'd2;

    localparam int unsigned CMD_RW_BIT = 15;
    localparam int unsigned CMD_MB_BIT = 14;
    localparam logic        READ_MODE  = 1'b1;
    localparam logic        WRITE_MODE = 1'b0;

    typedef struct packed {
        logic       rw;
        logic       mb;
        logic [5:0] addr;
        logic [7:0] wdata;
    } spi_cmd_t;

    function automatic logic is_read(input spi_cmd_t cmd);
        return cmd.rw == READ_MODE;
    endfunction

endpackage

// File: rtl/spi_txn_arbiter_if.sv
// Requester and SPI-engine bundle for spi_txn_arbiter; slave = arbiter side, master = requesters/engine.
interface spi_txn_arbiter_if
    import spi_arb_pkg::*;
#(
    parameter int unsigned NREQ = 3
);

    logic [NREQ-1:0]       iREQ;
    logic [NREQ*CMD_W-1:0] iCMD;
    logic [NREQ-1:0]       oGNT;
    logic [NREQ-1:0]       oDONE;
    logic [DATA_W-1:0]     oRDATA;
    logic [CMD_W-1:0]      oP2S_DATA;
    logic                  oSPI_GO;
    logic                  iSPI_END;
    logic [DATA_W-1:0]     iS2P_DATA;
    logic                  oBUSY;
    logic                  oTIMEOUT;

    modport slave (
        input  iREQ, iCMD, iSPI_END, iS2P_DATA,
        output oGNT, oDONE, oRDATA, oP2S_DATA, oSPI_GO, oBUSY, oTIMEOUT
    );

    modport master (
        output iREQ, iCMD, iSPI_END, iS2P_DATA,
        input  oGNT, oDONE, oRDATA, oP2S_DATA, oSPI_GO, oBUSY, oTIMEOUT
    );

endinterface

// File: rtl/spi_txn_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or above ptr, wrapping modulo NREQ.
module rr_pick #(
    parameter int unsigned NREQ  = 3,
    parameter int unsigned PTR_W = $clog2(NREQ)
) (
    input  logic [NREQ-1:0]  req,
    input  logic [PTR_W-1:0] ptr,
    output logic [NREQ-1:0]  gnt,
    output logic [PTR_W-1:0] idx,
    output logic             valid
);

    always_comb begin
        int unsigned pos;
        gnt   = '0;
        idx   = '0;
        valid = 1'b0;
        pos   = 0;
        for (int unsigned off = 0; off < NREQ; off++) begin
            pos = (32'(ptr) + off) % NREQ;
            if (!valid && req[pos]) begin
                valid    = 1'b1;
                gnt[pos] = 1'b1;
                idx      = PTR_W'(pos);
            end
        end
    end

endmodule

// File: rtl/spi_txn_arbiter.sv
// Round-robin arbiter sharing one SPI transaction engine among NREQ requesters.
// Optional transfer watchdog enabled by defining SPI_ARB_TIMEOUT_EN.
module spi_txn_arbiter
    import spi_arb_pkg::*;
#(
    parameter int unsigned NREQ        = 3,
    parameter int unsigned TIMEOUT_CYC = 1023
) (
    input  logic                iSPI_CLK,
    input  logic                iRSTN,
    spi_txn_arbiter_if.slave    bus
);

    localparam int unsigned PTR_W = $clog2(NREQ);

    logic [1:0]       state;
    logic [PTR_W-1:0] ptr;
    logic [PTR_W-1:0] win_idx;
    logic [NREQ-1:0]  pick_gnt;
    logic [PTR_W-1:0] pick_idx;
    logic             pick_valid;

`ifdef SPI_ARB_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC + 1);
    logic [CNT_W-1:0] tmo_cnt;
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = ^TIMEOUT_CYC;
    assign bus.oTIMEOUT       = 1'b0;
`endif

    rr_pick #(
        .NREQ  (NREQ),
        .PTR_W (PTR_W)
    ) u_pick (
        .req   (bus.iREQ),
        .ptr   (ptr),
        .gnt   (pick_gnt),
        .idx   (pick_idx),
        .valid (pick_valid)
    );

    assign bus.oBUSY = (state != ST_IDLE);

    always_ff @(posedge iSPI_CLK or negedge iRSTN) begin
        if (!iRSTN) begin
            state         <= ST_IDLE;
            ptr           <= '0;
            win_idx       <= '0;
            bus.oGNT      <= '0;
            bus.oDONE     <= '0;
            bus.oRDATA    <= '0;
            bus.oP2S_DATA <= '0;
            bus.oSPI_GO   <= 1'b0;
`ifdef SPI_ARB_TIMEOUT_EN
            bus.oTIMEOUT  <= 1'b0;
            tmo_cnt       <= '0;
`endif
        end else begin
            bus.oDONE <= '0;
`ifdef SPI_ARB_TIMEOUT_EN
            bus.oTIMEOUT <= 1'b0;
`endif
            case (state)
                ST_IDLE: begin
                    if (pick_valid) begin
                        state         <= ST_XFER;
                        win_idx       <= pick_idx;
                        bus.oGNT      <= pick_gnt;
                        bus.oP2S_DATA <= bus.iCMD[32'(pick_idx)*CMD_W +: CMD_W];
                        bus.oSPI_GO   <= 1'b1;
`ifdef SPI_ARB_TIMEOUT_EN
                        tmo_cnt       <= '0;
`endif
                    end
                end
                ST_XFER: begin
                    // oGNT is one-hot, so it doubles as the done-pulse mask for the winner
                    if (bus.iSPI_END) begin
                        state       <= ST_RELEASE;
                        bus.oRDATA  <= bus.iS2P_DATA;
                        bus.oSPI_GO <= 1'b0;
                        bus.oDONE   <= bus.oGNT;
`ifdef SPI_ARB_TIMEOUT_EN
                    end else if (tmo_cnt == CNT_W'(TIMEOUT_CYC - 1)) begin
                        state        <= ST_RELEASE;
                        bus.oRDATA   <= '0;
                        bus.oSPI_GO  <= 1'b0;
                        bus.oDONE    <= bus.oGNT;
                        bus.oTIMEOUT <= 1'b1;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
`endif
                    end
                end
                ST_RELEASE: begin
                    state    <= ST_IDLE;
                    bus.oGNT <= '0;
                    ptr      <= (32'(win_idx) == NREQ - 1) ? '0 : win_idx + 1'b1;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
